// File: rtl/counter_pkg.sv
// Shared types and defaults for the parameterised up/down counter.
//   mode_e  : step behaviour at a terminal value (Rsvd behaves like Wrap)
//   state_e : RUN counts normally; DONE freezes until set or reset
package counter_pkg;

    localparam int unsigned DefaultWidth     = 8;
    localparam int unsigned DefaultPrescaleW = 4;

    typedef enum logic [1:0] {
        ModeWrap     = 2'b00,
        ModeSaturate = 2'b01,
        ModeOneshot  = 2'b10,
        ModeRsvd     = 2'b11
    } mode_e;

    typedef enum logic {
        StRun  = 1'b0,
        StDone = 1'b1
    } state_e;

endpackage

// File: rtl/param_updown_counter_if.sv
// Control and status bundle for param_updown_counter.
//   slave  : the counter side (controls in, count/flags out)
//   master : the driver side (controls out, count/flags in)
interface param_updown_counter_if
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH      = DefaultWidth,
    parameter int unsigned PRESCALE_W = DefaultPrescaleW
);
    logic                  en_ctrl_in;
    logic                  set_ctrl_in;
    logic                  up_ctrl_in;
    logic [WIDTH-1:0]      counter_in;
    logic [WIDTH-1:0]      limit_in;
    logic [1:0]            mode_in;
    logic [PRESCALE_W-1:0] prescale_in;
    logic                  clr_flags_in;
    logic [WIDTH-1:0]      counter_out;
    logic                  ovf_out;
    logic                  udf_out;
    logic                  ovf_sticky_out;
    logic                  udf_sticky_out;
    logic                  tc_out;
    logic                  done_out;

    modport slave (
        input  en_ctrl_in, set_ctrl_in, up_ctrl_in, counter_in, limit_in, mode_in,
               prescale_in, clr_flags_in,
        output counter_out, ovf_out, udf_out, ovf_sticky_out, udf_sticky_out, tc_out,
               done_out
    );

    modport master (
        output en_ctrl_in, set_ctrl_in, up_ctrl_in, counter_in, limit_in, mode_in,
               prescale_in, clr_flags_in,
        input  counter_out, ovf_out, udf_out, ovf_sticky_out, udf_sticky_out, tc_out,
               done_out
    );

endinterface

// File: rtl/counter_prescaler.sv
// Step-rate divider: issues one tick every prescale+1 enabled cycles.
//   clk_in, nrst_in : clock, async active-low reset
//   en              : advance the divider this cycle
//   reload          : restart the divider from 0 (wins over en, no tick)
//   prescale        : divide ratio minus one
//   tick            : combinational, high in the cycle the step is taken
module counter_prescaler #(
    parameter int unsigned PRESCALE_W = 4
) (
    input  logic                  clk_in,
    input  logic                  nrst_in,
    input  logic                  en,
    input  logic                  reload,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (reload) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == prescale) begin
                tick  = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + PRESCALE_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/param_updown_counter.sv
// Prescaled up/down counter with wrap, saturate and one-shot terminal behaviour.
//   clk_in  : clock, all state on rising edge
//   nrst_in : asynchronous active-low reset
//   bus     : control inputs (enable, load, direction, limit, mode, prescale, flag clear)
//             and status outputs (count, ovf/udf pulses and sticky flags, tc, done)
module param_updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH      = DefaultWidth,
    parameter int unsigned PRESCALE_W = DefaultPrescaleW
) (
    input  logic                   clk_in,
    input  logic                   nrst_in,
    param_updown_counter_if.slave  bus
);

    logic [WIDTH-1:0] count_q, count_d;
    state_e           state_q, state_d;
    logic             ovf_q, ovf_d, udf_q, udf_d;
    logic             ovf_sticky_q, ovf_sticky_d, udf_sticky_q, udf_sticky_d;
    logic             tick;
    mode_e            mode;

    assign mode = mode_e'(bus.mode_in);

    counter_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk_in   (clk_in),
        .nrst_in  (nrst_in),
        .en       (bus.en_ctrl_in && (state_q == StRun)),
        .reload   (bus.set_ctrl_in),
        .prescale (bus.prescale_in),
        .tick     (tick)
    );

    always_comb begin
        count_d = count_q;
        state_d = state_q;
        ovf_d   = 1'b0;
        udf_d   = 1'b0;
        if (bus.set_ctrl_in) begin
            // Load is clamped so the count never starts above the terminal value.
            count_d = (bus.counter_in > bus.limit_in) ? bus.limit_in : bus.counter_in;
            state_d = StRun;
        end else if (tick) begin
            if (bus.up_ctrl_in) begin
                if (count_q >= bus.limit_in) begin
                    ovf_d = 1'b1;
                    case (mode)
                        ModeSaturate: count_d = count_q;
                        ModeOneshot:  state_d = StDone;
                        default:      count_d = '0;
                    endcase
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (count_q == '0) begin
                    udf_d = 1'b1;
                    case (mode)
                        ModeSaturate: count_d = count_q;
                        ModeOneshot:  state_d = StDone;
                        default:      count_d = bus.limit_in;
                    endcase
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
        // A new pulse beats a simultaneous clear.
        ovf_sticky_d = ovf_d | (ovf_sticky_q & ~bus.clr_flags_in);
        udf_sticky_d = udf_d | (udf_sticky_q & ~bus.clr_flags_in);
    end

    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            count_q      <= '0;
            state_q      <= StRun;
            ovf_q        <= 1'b0;
            udf_q        <= 1'b0;
            ovf_sticky_q <= 1'b0;
            udf_sticky_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            state_q      <= state_d;
            ovf_q        <= ovf_d;
            udf_q        <= udf_d;
            ovf_sticky_q <= ovf_sticky_d;
            udf_sticky_q <= udf_sticky_d;
        end
    end

    assign bus.counter_out    = count_q;
    assign bus.ovf_out        = ovf_q;
    assign bus.udf_out        = udf_q;
    assign bus.ovf_sticky_out = ovf_sticky_q;
    assign bus.udf_sticky_out = udf_sticky_q;
    assign bus.done_out       = (state_q == StDone);
    assign bus.tc_out         = bus.up_ctrl_in ? (count_q >= bus.limit_in) : (count_q == '0);

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed scoreboard bench for param_updown_counter (WIDTH=8, PRESCALE_W=4).
// Stimulus pushes the hand-computed post-edge response; a monitor pops and
// compares on every falling edge.
module tb_param_updown_counter;

    logic clk;
    logic nrst;

    param_updown_counter_if #(.WIDTH(8), .PRESCALE_W(4)) bus ();

    param_updown_counter #(
        .WIDTH      (8),
        .PRESCALE_W (4)
    ) dut (
        .clk_in  (clk),
        .nrst_in (nrst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Packed response: {count[7:0], ovf, udf, ovf_sticky, udf_sticky, tc, done}
    logic [13:0] exp_q[$];
    string       name_q[$];

    function automatic logic [13:0] actual();
        return {bus.counter_out, bus.ovf_out, bus.udf_out, bus.ovf_sticky_out,
                bus.udf_sticky_out, bus.tc_out, bus.done_out};
    endfunction

    task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got cnt=%0d flags(ovf,udf,ovfs,udfs,tc,done)=%b, expected cnt=%0d flags=%b",
                     name, act[13:6], act[5:0], exp[13:6], exp[5:0]);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            check(name_q.pop_front(), actual(), exp_q.pop_front());
        end
    end

    task automatic cfg(input logic up, input logic [7:0] lim, input logic [1:0] mode,
                       input logic [3:0] pre);
        bus.up_ctrl_in  = up;
        bus.limit_in    = lim;
        bus.mode_in     = mode;
        bus.prescale_in = pre;
    endtask

    // Called just after a falling edge: drive one cycle of inputs, expect the
    // response after the next rising edge, return just after the following fall.
    task automatic cyc(input string name, input logic set, input logic en, input logic clr,
                       input logic [7:0] cin, input logic [7:0] c, input logic o,
                       input logic u, input logic os, input logic us, input logic tc,
                       input logic dn);
        bus.set_ctrl_in  = set;
        bus.en_ctrl_in   = en;
        bus.clr_flags_in = clr;
        bus.counter_in   = cin;
        exp_q.push_back({c, o, u, os, us, tc, dn});
        name_q.push_back(name);
        @(negedge clk);
        #1;
    endtask

    initial begin
        nrst = 1'b0;
        bus.set_ctrl_in  = 1'b0;
        bus.en_ctrl_in   = 1'b0;
        bus.clr_flags_in = 1'b0;
        bus.counter_in   = '0;
        cfg(1'b1, 8'd5, 2'b00, 4'd0);
        @(negedge clk);
        #1;
        check("reset_state", actual(), {8'd0, 6'b000000});
        nrst = 1'b1;
        @(negedge clk);
        #1;

        // Wrap up-count 0..5 then 0 with ovf
        cyc("wrap_up1",  0, 1, 0, 0,   1, 0, 0, 0, 0, 0, 0);
        cyc("wrap_up2",  0, 1, 0, 0,   2, 0, 0, 0, 0, 0, 0);
        cyc("wrap_up3",  0, 1, 0, 0,   3, 0, 0, 0, 0, 0, 0);
        cyc("wrap_up4",  0, 1, 0, 0,   4, 0, 0, 0, 0, 0, 0);
        cyc("wrap_up5",  0, 1, 0, 0,   5, 0, 0, 0, 0, 1, 0);
        cyc("wrap_ovf",  0, 1, 0, 0,   0, 1, 0, 1, 0, 0, 0);
        cyc("wrap_clr",  0, 0, 1, 0,   0, 0, 0, 0, 0, 0, 0);

        // limit=0: every tick wraps to 0 with ovf
        cfg(1'b1, 8'd0, 2'b00, 4'd0);
        cyc("lim0_a",       0, 1, 0, 0,   0, 1, 0, 1, 0, 1, 0);
        cyc("lim0_b",       0, 1, 0, 0,   0, 1, 0, 1, 0, 1, 0);
        cyc("lim0_pls_clr", 0, 1, 1, 0,   0, 1, 0, 1, 0, 1, 0);
        cyc("lim0_clr",     0, 0, 1, 0,   0, 0, 0, 0, 0, 1, 0);

        // Saturate down from 2
        cfg(1'b0, 8'd5, 2'b01, 4'd0);
        cyc("sat_set",   1, 0, 0, 2,   2, 0, 0, 0, 0, 0, 0);
        cyc("sat_dn1",   0, 1, 0, 0,   1, 0, 0, 0, 0, 0, 0);
        cyc("sat_dn0",   0, 1, 0, 0,   0, 0, 0, 0, 0, 1, 0);
        cyc("sat_udf1",  0, 1, 0, 0,   0, 0, 1, 0, 1, 1, 0);
        cyc("sat_udf2",  0, 1, 0, 0,   0, 0, 1, 0, 1, 1, 0);
        cyc("sat_hold",  0, 0, 0, 0,   0, 0, 0, 0, 1, 1, 0);
        cyc("sat_clr",   0, 0, 1, 0,   0, 0, 0, 0, 0, 1, 0);

        // Wrap down from 0 reloads limit; count above a lowered limit decrements
        cfg(1'b0, 8'd5, 2'b00, 4'd0);
        cyc("wrap_dn_udf",  0, 1, 0, 0,   5, 0, 1, 0, 1, 0, 0);
        cfg(1'b0, 8'd2, 2'b00, 4'd0);
        cyc("dn_above_lim", 0, 1, 1, 0,   4, 0, 0, 0, 0, 0, 0);

        // One-shot up to 3, then frozen in DONE until set
        cfg(1'b1, 8'd3, 2'b10, 4'd0);
        cyc("os_set",    1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
        cyc("os_1",      0, 1, 0, 0,   1, 0, 0, 0, 0, 0, 0);
        cyc("os_2",      0, 1, 0, 0,   2, 0, 0, 0, 0, 0, 0);
        cyc("os_3",      0, 1, 0, 0,   3, 0, 0, 0, 0, 1, 0);
        cyc("os_done",   0, 1, 0, 0,   3, 1, 0, 1, 0, 1, 1);
        for (int i = 0; i < 10; i++) begin
            cyc("os_hold", 0, 1, 0, 0,   3, 0, 0, 1, 0, 1, 1);
        end
        cyc("os_reload", 1, 0, 0, 1,   1, 0, 0, 1, 0, 0, 0);
        cyc("os_clr",    0, 0, 1, 0,   1, 0, 0, 0, 0, 0, 0);

        // prescale=3 with en 1,1,0,1,1: one step on the fourth enabled cycle
        cfg(1'b1, 8'd100, 2'b00, 4'd3);
        cyc("pre_set",   1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
        cyc("pre_e1",    0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0);
        cyc("pre_e2",    0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0);
        cyc("pre_off",   0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
        cyc("pre_e3",    0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0);
        cyc("pre_e4",    0, 1, 0, 0,   1, 0, 0, 0, 0, 0, 0);
        cyc("pre_f1",    0, 1, 0, 0,   1, 0, 0, 0, 0, 0, 0);
        cyc("pre_f2",    0, 1, 0, 0,   1, 0, 0, 0, 0, 0, 0);
        cyc("pre_f3",    0, 1, 0, 0,   1, 0, 0, 0, 0, 0, 0);
        cyc("pre_f4",    0, 1, 0, 0,   2, 0, 0, 0, 0, 0, 0);

        // Load clamps to limit and beats a same-cycle step
        cfg(1'b1, 8'd100, 2'b00, 4'd0);
        cyc("clamp_set",  1, 1, 0, 200, 100, 0, 0, 0, 0, 1, 0);
        cyc("clamp_hold", 0, 0, 0, 0,   100, 0, 0, 0, 0, 1, 0);
        cyc("clamp_wrap", 0, 1, 0, 0,   0, 1, 0, 1, 0, 0, 0);
        cyc("clamp_clr",  0, 0, 1, 0,   0, 0, 0, 0, 0, 0, 0);

        // Reserved mode behaves as wrap
        cfg(1'b1, 8'd1, 2'b11, 4'd0);
        cyc("rsvd_1",     0, 1, 0, 0,   1, 0, 0, 0, 0, 1, 0);
        cyc("rsvd_wrap",  0, 1, 0, 0,   0, 1, 0, 1, 0, 0, 0);

        // Async reset while in DONE
        cfg(1'b1, 8'd2, 2'b10, 4'd0);
        cyc("rst_set",    1, 0, 1, 0,   0, 0, 0, 0, 0, 0, 0);
        cyc("rst_1",      0, 1, 0, 0,   1, 0, 0, 0, 0, 0, 0);
        cyc("rst_2",      0, 1, 0, 0,   2, 0, 0, 0, 0, 1, 0);
        cyc("rst_done",   0, 1, 0, 0,   2, 1, 0, 1, 0, 1, 1);
        cyc("rst_dhold",  0, 0, 0, 0,   2, 0, 0, 1, 0, 1, 1);
        #1;
        nrst = 1'b0;
        #1;
        check("async_rst", actual(), {8'd0, 6'b000000});
        #1;
        nrst = 1'b1;
        @(negedge clk);
        #1;
        cyc("post_rst",   0, 1, 0, 0,   1, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        check("drain", {10'd0, 4'(exp_q.size())}, 14'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
